// File: rtl/rf_arb_pkg.sv
// Register-file writeback arbiter shared types.
// State encoding, source tags and address width.
package rf_arb_pkg;

  typedef enum logic {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering source-B writebacks.
// Pointers wrap modulo DEPTH (power of two).
module rf_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between A and B.
// A has priority; an aging counter forces B after a stall.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int B_DEPTH      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [REG_ADDR_W-1:0]   a_addr,
  input  logic [XLEN-1:0]         a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [REG_ADDR_W-1:0]   b_addr,
  input  logic [XLEN-1:0]         b_data,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    rf_src,
  output logic [$clog2(B_DEPTH):0] b_count
);

  localparam int FW = REG_ADDR_W + XLEN;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  src_q, src_d;

  logic [FW-1:0]         head;
  logic                  full, empty;
  logic                  force_b, gnt_a, gnt_b;

  rf_wb_fifo #(
    .W     (FW),
    .DEPTH (B_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (b_valid & b_ready),
    .pop_i   (gnt_b),
    .wdata_i ({b_addr, b_data}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (b_count)
  );

  assign b_ready = ~full;
  assign force_b = (state_q == FORCE_B) & ~empty;
  assign a_ready = ~force_b;
  assign gnt_a   = a_valid & ~force_b;
  assign gnt_b   = force_b | (~a_valid & ~empty);

  // Grant mux and next output-register values.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    src_d   = src_q;
    if (gnt_b) begin
      waddr_d = head[FW-1 -: REG_ADDR_W];
      wdata_d = head[XLEN-1:0];
      src_d   = SRC_B;
      we_d    = (waddr_d != '0);
    end else if (gnt_a) begin
      waddr_d = a_addr;
      wdata_d = a_data;
      src_d   = SRC_A;
      we_d    = (a_addr != '0);
    end
  end

  // Aging FSM: count denied cycles, force one B grant.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      PRIO_A: begin
        if (~empty & ~gnt_b) begin
          if (wait_q >= WW'(STARVE_LIMIT - 1)) begin
            wait_d  = WW'(STARVE_LIMIT);
            state_d = FORCE_B;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
      end
      FORCE_B: begin
        state_d = PRIO_A;
      end
      default: state_d = PRIO_A;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIO_A;
      wait_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      src_q   <= SRC_A;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign rf_src   = src_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vector bench for rf_wb_arbiter.
// Default parameters: XLEN=32, B_DEPTH=2, STARVE_LIMIT=4.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid, b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_src;
  logic [1:0]  b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_src   (rf_src),
    .b_count  (b_count)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        src;
    logic [1:0]  cnt;
    logic        ar;
    logic        br;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic r, av, input logic [4:0] aa, input logic [31:0] ad,
    input logic bv, input logic [4:0] ba, input logic [31:0] bd,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic src, input logic [1:0] cnt, input logic ar, br);
    vec_t v;
    v.rst = r;  v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv;  v.ba = ba; v.bd = bd;
    v.we = we;  v.wa = wa; v.wd = wd; v.src = src;
    v.cnt = cnt; v.ar = ar; v.br = br;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, av, input logic [4:0] aa,
                       input logic [31:0] ad, input logic bv,
                       input logic [4:0] ba, input logic [31:0] bd);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    //          rst av aa  ad            bv ba  bd       we wa  wd            src cnt ar br
    vt.push_back(mk(1,0, 0, 32'h0,       0, 0, 32'h0,    0, 0, 32'h0,       0, 0, 1, 1));
    vt.push_back(mk(0,1, 5, 32'hDEADBEEF,0, 0, 32'h0,    1, 5, 32'hDEADBEEF,0, 0, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       0, 0, 32'h0,    0, 5, 32'hDEADBEEF,0, 0, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       1, 7, 32'h1234, 0, 5, 32'hDEADBEEF,0, 1, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       0, 0, 32'h0,    1, 7, 32'h1234,    1, 0, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       0, 0, 32'h0,    0, 7, 32'h1234,    1, 0, 1, 1));
    vt.push_back(mk(0,1, 0, 32'hFFFFFFFF,0, 0, 32'h0,    0, 0, 32'hFFFFFFFF,0, 0, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       1, 0, 32'hAAAA, 0, 0, 32'hFFFFFFFF,0, 1, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       0, 0, 32'h0,    0, 0, 32'hAAAA,    1, 0, 1, 1));
    vt.push_back(mk(0,1, 1, 32'h11,      1, 9, 32'h99,   1, 1, 32'h11,      0, 1, 1, 1));
    vt.push_back(mk(0,1, 2, 32'h22,      0, 0, 32'h0,    1, 2, 32'h22,      0, 1, 1, 1));
    vt.push_back(mk(0,1, 3, 32'h33,      0, 0, 32'h0,    1, 3, 32'h33,      0, 1, 1, 1));
    vt.push_back(mk(0,1, 4, 32'h44,      0, 0, 32'h0,    1, 4, 32'h44,      0, 1, 1, 1));
    vt.push_back(mk(0,1, 5, 32'h55,      0, 0, 32'h0,    1, 5, 32'h55,      0, 1, 0, 1));
    vt.push_back(mk(0,1, 6, 32'h66,      0, 0, 32'h0,    1, 9, 32'h99,      1, 0, 1, 1));
    vt.push_back(mk(0,1, 7, 32'h77,      0, 0, 32'h0,    1, 7, 32'h77,      0, 0, 1, 1));
    vt.push_back(mk(0,1, 8, 32'h88,      1,10, 32'hA0,   1, 8, 32'h88,      0, 1, 1, 1));
    vt.push_back(mk(0,1,11, 32'hB1,      1,12, 32'hC0,   1,11, 32'hB1,      0, 2, 1, 0));
    vt.push_back(mk(0,1,13, 32'hD1,      1,14, 32'hE0,   1,13, 32'hD1,      0, 2, 1, 0));
    vt.push_back(mk(0,1,15, 32'hF1,      1,14, 32'hE0,   1,15, 32'hF1,      0, 2, 1, 0));
    vt.push_back(mk(0,1,16, 32'h101,     1,14, 32'hE0,   1,16, 32'h101,     0, 2, 0, 0));
    vt.push_back(mk(0,1,17, 32'h111,     1,14, 32'hE0,   1,10, 32'hA0,      1, 1, 1, 1));
    vt.push_back(mk(0,1,18, 32'h121,     1,14, 32'hE0,   1,18, 32'h121,     0, 2, 1, 0));
    vt.push_back(mk(0,0, 0, 32'h0,       0, 0, 32'h0,    1,12, 32'hC0,      1, 1, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       0, 0, 32'h0,    1,14, 32'hE0,      1, 0, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       1,20, 32'h200,  0,14, 32'hE0,      1, 1, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       1,21, 32'h210,  1,20, 32'h200,     1, 1, 1, 1));
    vt.push_back(mk(0,1, 3, 32'h33,      1,22, 32'h220,  1, 3, 32'h33,      0, 2, 1, 0));
    vt.push_back(mk(1,1, 4, 32'h44,      0, 0, 32'h0,    0, 0, 32'h0,       0, 0, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       0, 0, 32'h0,    0, 0, 32'h0,       0, 0, 1, 1));
    vt.push_back(mk(0,0, 0, 32'h0,       0, 0, 32'h0,    0, 0, 32'h0,       0, 0, 1, 1));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].av, vt[i].aa, vt[i].ad,
            vt[i].bv, vt[i].ba, vt[i].bd);
      tick();
      chk("rf_we",    i, 32'(rf_we),    32'(vt[i].we));
      chk("rf_waddr", i, 32'(rf_waddr), 32'(vt[i].wa));
      chk("rf_wdata", i, rf_wdata,      vt[i].wd);
      chk("rf_src",   i, 32'(rf_src),   32'(vt[i].src));
      chk("b_count",  i, 32'(b_count),  32'(vt[i].cnt));
      chk("a_ready",  i, 32'(a_ready),  32'(vt[i].ar));
      chk("b_ready",  i, 32'(b_ready),  32'(vt[i].br));
    end

    // A natural B grant must clear the aging counter.
    drive(0, 1, 1, 32'h1, 1, 25, 32'h250);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 2, 32'h2, 0, 0, 32'h0);
      tick();
      chk("age_a_ready_pre", k, 32'(a_ready), 32'd1);
    end
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    chk("age_b_src",   100, 32'(rf_src),   32'd1);
    chk("age_b_addr",  100, 32'(rf_waddr), 32'd25);
    chk("age_b_count", 100, 32'(b_count),  32'd0);
    drive(0, 1, 3, 32'h3, 1, 26, 32'h260);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 4, 32'h4, 0, 0, 32'h0);
      tick();
      chk("age_a_ready_post", k, 32'(a_ready), 32'd1);
    end
    drive(0, 1, 5, 32'h5, 0, 0, 32'h0);
    tick();
    chk("age_force", 101, 32'(a_ready), 32'd0);
    drive(0, 1, 6, 32'h6, 0, 0, 32'h0);
    tick();
    chk("age_force_addr", 102, 32'(rf_waddr), 32'd26);
    chk("age_force_src",  102, 32'(rf_src),   32'd1);
    chk("age_resume",     102, 32'(a_ready),  32'd1);
    drive(0, 1, 6, 32'h6, 0, 0, 32'h0);
    tick();
    chk("age_a_after", 103, 32'(rf_waddr), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
